// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the memory image loader.
// The VERIFY state is reachable only when MEM_LOADER_VERIFY_EN is defined.
package mem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic MEM_WRITE = 1'b0;
  localparam logic MEM_READ  = 1'b1;

endpackage

// File: rtl/mem_checksum.sv
// Modular (wrap-around) DATA_W-bit accumulator with synchronous clear and add-enable.
// Clear wins over add.
module mem_checksum #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_add,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_sum
);

  logic [DATA_W-1:0] r_sum;

  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_sum <= '0;
    end else if (i_add) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/mem_loader.sv
// Streams an image from a valid/ready source into memory, optionally reading it back and
// comparing checksums. Define MEM_LOADER_VERIFY_EN to route LOAD through the VERIFY readback.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 32,
  parameter int          CNT_W     = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned STRIDE    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_last,
  output logic              src_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              mem_rw,
  output logic              mem_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W:0]    word_count,
  output logic              sum_ok,
  output state_t            dbg_state
);

  // Handshake: a source word transfers on any cycle where src_valid && src_ready; src_ready
  // is high for the whole of LOAD, so the source may present or withhold words freely.

  localparam logic [CNT_W:0] LAST_IDX = {1'b0, {CNT_W{1'b1}}};
  localparam logic [CNT_W:0] CNT_ONE  = {{CNT_W{1'b0}}, 1'b1};

  state_t            r_state;
  logic [CNT_W:0]    r_word_count;
  logic [CNT_W:0]    r_rd_idx;
  logic              r_rd_pend;
  logic              r_sum_ok;

  logic              w_start_ok;
  logic              w_accept;
  logic              w_load_end;
  logic              w_rd_issue;
  logic [CNT_W:0]    w_idx;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wr_sum;
  logic [DATA_W-1:0] w_rd_sum;
  logic [DATA_W-1:0] w_rd_final;

  assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_accept   = (r_state == ST_LOAD) && src_valid;
  assign w_load_end = w_accept && (src_last || r_word_count == LAST_IDX);
  assign w_rd_issue = (r_state == ST_VERIFY) && (r_rd_idx < r_word_count);
  assign w_idx      = (r_state == ST_VERIFY) ? r_rd_idx : r_word_count;
  assign w_addr     = ADDR_W'(BASE_ADDR) + ADDR_W'(STRIDE) * ADDR_W'(w_idx);

  // The last readback word lands in the same cycle VERIFY exits, so fold it in here.
  assign w_rd_final = w_rd_sum + (r_rd_pend ? mem_data_out : '0);

  mem_checksum #(.DATA_W(DATA_W)) u_wr_sum (
    .clock  (clock),
    .reset  (reset),
    .i_clear(w_start_ok),
    .i_add  (w_accept),
    .i_data (src_data),
    .o_sum  (w_wr_sum)
  );

  mem_checksum #(.DATA_W(DATA_W)) u_rd_sum (
    .clock  (clock),
    .reset  (reset),
    .i_clear(w_start_ok),
    .i_add  (r_rd_pend),
    .i_data (mem_data_out),
    .o_sum  (w_rd_sum)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_word_count <= '0;
      r_rd_idx     <= '0;
      r_rd_pend    <= 1'b0;
      r_sum_ok     <= 1'b0;
    end else begin
      r_rd_pend <= w_rd_issue;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state      <= ST_LOAD;
            r_word_count <= '0;
            r_rd_idx     <= '0;
            r_sum_ok     <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_word_count <= r_word_count + CNT_ONE;
            if (w_load_end) begin
`ifdef MEM_LOADER_VERIFY_EN
              r_state <= ST_VERIFY;
`else
              r_state  <= ST_DONE;
              r_sum_ok <= 1'b1;
`endif
            end
          end
        end
        ST_VERIFY: begin
          if (w_rd_issue) begin
            r_rd_idx <= r_rd_idx + CNT_ONE;
          end else begin
            r_state  <= ST_DONE;
            r_sum_ok <= (w_rd_final == w_wr_sum);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    src_ready   = 1'b0;
    mem_en      = 1'b0;
    mem_rw      = MEM_READ;
    mem_addr    = ADDR_W'(BASE_ADDR);
    mem_data_in = '0;
    if (r_state == ST_LOAD) begin
      src_ready   = 1'b1;
      mem_en      = src_valid;
      mem_rw      = MEM_WRITE;
      mem_addr    = w_addr;
      mem_data_in = src_data;
    end else if (w_rd_issue) begin
      mem_en   = 1'b1;
      mem_addr = w_addr;
    end
  end

  assign busy       = (r_state == ST_LOAD) || (r_state == ST_VERIFY);
  assign done       = (r_state == ST_DONE);
  assign word_count = r_word_count;
  assign sum_ok     = r_sum_ok;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: a default-sized instance plus a CNT_W=2 instance for the size cap.
// Expected writes, reads, counts and checksum outcome come from an image-level model.
module tb_mem_loader;
  import mem_loader_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int CW  = 10;
  localparam int SCW = 2;
  localparam logic [AW-1:0] CORRUPT_ADDR = 32'h4;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;

  // default instance
  logic          start, src_valid, src_last, src_ready;
  logic [DW-1:0] src_data, mem_data_in, mem_data_out;
  logic [AW-1:0] mem_addr;
  logic          mem_rw, mem_en, busy, done, sum_ok;
  logic [CW:0]   word_count;
  state_t        dbg_state;

  // small instance
  logic          s_start, s_src_valid, s_src_last, s_src_ready;
  logic [DW-1:0] s_src_data, s_mem_data_in, s_mem_data_out;
  logic [AW-1:0] s_mem_addr;
  logic          s_mem_rw, s_mem_en, s_busy, s_done, s_sum_ok;
  logic [SCW:0]  s_word_count;
  state_t        s_dbg_state;

  mem_loader dut (
    .clock(clock), .reset(reset), .start(start), .src_valid(src_valid), .src_data(src_data),
    .src_last(src_last), .src_ready(src_ready), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_rw(mem_rw), .mem_en(mem_en), .busy(busy), .done(done),
    .word_count(word_count), .sum_ok(sum_ok), .dbg_state(dbg_state)
  );

  mem_loader #(.CNT_W(SCW)) dut_s (
    .clock(clock), .reset(reset), .start(s_start), .src_valid(s_src_valid), .src_data(s_src_data),
    .src_last(s_src_last), .src_ready(s_src_ready), .mem_addr(s_mem_addr),
    .mem_data_in(s_mem_data_in), .mem_data_out(s_mem_data_out), .mem_rw(s_mem_rw),
    .mem_en(s_mem_en), .busy(s_busy), .done(s_done), .word_count(s_word_count),
    .sum_ok(s_sum_ok), .dbg_state(s_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- bench memories ----------------
  logic          corrupt_en = 1'b0;
  logic [DW-1:0] mem_m [0:1023];
  logic [DW-1:0] mem_s [0:15];

  always @(posedge clock) begin
    if (mem_en && mem_rw == MEM_WRITE) mem_m[mem_addr[11:2]] <= mem_data_in;
    if (mem_en && mem_rw == MEM_READ)
      mem_data_out <= (corrupt_en && mem_addr == CORRUPT_ADDR) ? '0 : mem_m[mem_addr[11:2]];
    if (s_mem_en && s_mem_rw == MEM_WRITE) mem_s[s_mem_addr[5:2]] <= s_mem_data_in;
    if (s_mem_en && s_mem_rw == MEM_READ) s_mem_data_out <= mem_s[s_mem_addr[5:2]];
  end

  // ---------------- monitor ----------------
  bit            mon_sel = 1'b0;
  int            done_cyc = -1;
  logic [AW-1:0] obs_wa[$];
  logic [DW-1:0] obs_wd[$];
  logic [AW-1:0] obs_ra[$];

  always @(negedge clock) begin
    if (!mon_sel) begin
      if (mem_en && mem_rw == MEM_WRITE) begin obs_wa.push_back(mem_addr); obs_wd.push_back(mem_data_in); end
      if (mem_en && mem_rw == MEM_READ) obs_ra.push_back(mem_addr);
      if (done && done_cyc < 0) done_cyc = cyc;
    end else begin
      if (s_mem_en && s_mem_rw == MEM_WRITE) begin obs_wa.push_back(s_mem_addr); obs_wd.push_back(s_mem_data_in); end
      if (s_mem_en && s_mem_rw == MEM_READ) obs_ra.push_back(s_mem_addr);
      if (s_done && done_cyc < 0) done_cyc = cyc;
    end
  end

  // ---------------- scoreboard / model ----------------
  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] img[$];
  logic [AW-1:0] exp_wa_q[$];
  logic [DW-1:0] exp_wd_q[$];
  logic [AW-1:0] exp_ra_q[$];
  int            exp_wc, exp_latency, n_acc, last_acc_cyc;
  logic          exp_sum_ok;
  bit            gap_en_seen;

  // Image-level reference: the first min(len, cap) words go to consecutive word addresses.
  task automatic model_load(input int cap, input bit corrupt);
    logic [DW-1:0] wsum, rsum;
    exp_wa_q.delete(); exp_wd_q.delete(); exp_ra_q.delete();
    exp_wc = (img.size() < cap) ? img.size() : cap;
    wsum = '0;
    rsum = '0;
    for (int i = 0; i < exp_wc; i++) begin
      exp_wa_q.push_back(AW'(4 * i));
      exp_wd_q.push_back(img[i]);
      wsum += img[i];
      rsum += (corrupt && AW'(4 * i) == CORRUPT_ADDR) ? '0 : img[i];
    end
`ifdef MEM_LOADER_VERIFY_EN
    for (int i = 0; i < exp_wc; i++) exp_ra_q.push_back(AW'(4 * i));
    exp_sum_ok  = (rsum == wsum);
    exp_latency = exp_wc + 2;
`else
    exp_sum_ok  = 1'b1;
    exp_latency = 1;
`endif
  endtask

  // ---------------- drivers ----------------
  task automatic set_src(input bit sel, input logic v, input logic [DW-1:0] d, input logic l);
    if (sel) begin s_src_valid = v; s_src_data = d; s_src_last = l; end
    else begin src_valid = v; src_data = d; src_last = l; end
  endtask

  task automatic pulse_start(input bit sel);
    obs_wa.delete(); obs_wd.delete(); obs_ra.delete();
    @(posedge clock); #1;
    if (sel) s_start = 1'b1; else start = 1'b1;
    @(posedge clock); #1;
    s_start = 1'b0;
    start   = 1'b0;
    done_cyc = -1;
  endtask

  task automatic drive_image(input bit sel, input bit with_last, input int gap_at, input int gap_len);
    n_acc = 0;
    gap_en_seen = 1'b0;
    for (int i = 0; i < img.size(); i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          set_src(sel, 1'b0, '0, 1'b0);
          if (!sel) start = (g == 1);
          @(negedge clock);
          if (sel ? s_mem_en : mem_en) gap_en_seen = 1'b1;
          @(posedge clock); #1;
        end
        start = 1'b0;
      end
      set_src(sel, 1'b1, img[i], with_last && (i == img.size() - 1));
      @(negedge clock);
      if (!(sel ? s_src_ready : src_ready)) break;
      n_acc++;
      last_acc_cyc = cyc;
      @(posedge clock); #1;
    end
    set_src(sel, 1'b0, '0, 1'b0);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 3000 && done_cyc < 0; k++) @(negedge clock);
    @(negedge clock);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0; s_start = 1'b0;
    set_src(1'b0, 1'b0, '0, 1'b0);
    set_src(1'b1, 1'b0, '0, 1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0d want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %0d want 0", done); end
    n_vec++; if (word_count !== '0) begin n_err++; $display("FAIL reset_wc got %0d want 0", word_count); end
    n_vec++; if (sum_ok !== 1'b0) begin n_err++; $display("FAIL reset_sum_ok got %0d want 0", sum_ok); end
    n_vec++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL reset_mem_en got %0d want 0", mem_en); end
    n_vec++; if (mem_rw !== 1'b1) begin n_err++; $display("FAIL reset_mem_rw got %0d want 1", mem_rw); end
    n_vec++; if (mem_addr !== '0) begin n_err++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    n_vec++; if (mem_data_in !== '0) begin n_err++; $display("FAIL reset_mem_data got %h want 0", mem_data_in); end
    n_vec++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL reset_src_ready got %0d want 0", src_ready); end
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state got %0d want %0d", dbg_state, ST_IDLE); end
    n_vec++; if (s_busy !== 1'b0 || s_word_count !== '0) begin n_err++; $display("FAIL reset_small got %0d/%0d want 0/0", s_busy, s_word_count); end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_fixed_image();
    mon_sel = 1'b0;
    img = {32'hABCDABCD, 32'hDEFADEFA, 32'h12341234};
    model_load(1 << CW, 1'b0);
    pulse_start(1'b0);
    drive_image(1'b0, 1'b1, -1, 0);
    wait_done();
    n_vec++; if (obs_wa.size() != exp_wa_q.size()) begin n_err++; $display("FAIL fixed_wr_cnt got %0d want %0d", obs_wa.size(), exp_wa_q.size()); end
    foreach (exp_wa_q[i]) if (i < obs_wa.size()) begin
      n_vec++;
      if (obs_wa[i] !== exp_wa_q[i] || obs_wd[i] !== exp_wd_q[i]) begin n_err++; $display("FAIL fixed_wr%0d got %h:%h want %h:%h", i, obs_wa[i], obs_wd[i], exp_wa_q[i], exp_wd_q[i]); end
    end
    n_vec++; if (obs_ra.size() != exp_ra_q.size()) begin n_err++; $display("FAIL fixed_rd_cnt got %0d want %0d", obs_ra.size(), exp_ra_q.size()); end
    foreach (exp_ra_q[i]) if (i < obs_ra.size()) begin
      n_vec++; if (obs_ra[i] !== exp_ra_q[i]) begin n_err++; $display("FAIL fixed_rd%0d got %h want %h", i, obs_ra[i], exp_ra_q[i]); end
    end
    n_vec++; if (done_cyc - last_acc_cyc != exp_latency) begin n_err++; $display("FAIL fixed_latency got %0d want %0d", done_cyc - last_acc_cyc, exp_latency); end
    repeat (3) @(negedge clock);
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL fixed_done got %0d want 1", done); end
    n_vec++; if (word_count !== (CW+1)'(exp_wc)) begin n_err++; $display("FAIL fixed_wc got %0d want %0d", word_count, exp_wc); end
    n_vec++; if (sum_ok !== exp_sum_ok) begin n_err++; $display("FAIL fixed_sum_ok got %0d want %0d", sum_ok, exp_sum_ok); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL fixed_busy got %0d want 0", busy); end
  endtask

  task automatic test_corrupt_readback();
    mon_sel = 1'b0;
    corrupt_en = 1'b1;
    img = {32'hABCDABCD, 32'hDEFADEFA, 32'h12341234};
    model_load(1 << CW, 1'b1);
    pulse_start(1'b0);
    drive_image(1'b0, 1'b1, -1, 0);
    wait_done();
    n_vec++; if (sum_ok !== exp_sum_ok) begin n_err++; $display("FAIL corrupt_sum_ok got %0d want %0d", sum_ok, exp_sum_ok); end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL corrupt_done got %0d want 1", done); end
    n_vec++; if (word_count !== (CW+1)'(exp_wc)) begin n_err++; $display("FAIL corrupt_wc got %0d want %0d", word_count, exp_wc); end
    corrupt_en = 1'b0;
  endtask

  task automatic test_gaps();
    int len, gap_at;
    mon_sel = 1'b0;
    for (int t = 0; t < 4; t++) begin
      len = $urandom_range(4, 10);
      gap_at = $urandom_range(1, len - 1);
      img.delete();
      for (int i = 0; i < len; i++) img.push_back($urandom());
      model_load(1 << CW, 1'b0);
      pulse_start(1'b0);
      drive_image(1'b0, 1'b1, gap_at, 3);
      wait_done();
      n_vec++; if (gap_en_seen !== 1'b0) begin n_err++; $display("FAIL gap%0d_mem_en got 1 want 0", t); end
      n_vec++; if (obs_wa.size() != exp_wa_q.size()) begin n_err++; $display("FAIL gap%0d_wr_cnt got %0d want %0d", t, obs_wa.size(), exp_wa_q.size()); end
      foreach (exp_wa_q[i]) if (i < obs_wa.size()) begin
        n_vec++;
        if (obs_wa[i] !== exp_wa_q[i] || obs_wd[i] !== exp_wd_q[i]) begin n_err++; $display("FAIL gap%0d_wr%0d got %h:%h want %h:%h", t, i, obs_wa[i], obs_wd[i], exp_wa_q[i], exp_wd_q[i]); end
      end
      n_vec++; if (obs_ra.size() != exp_ra_q.size()) begin n_err++; $display("FAIL gap%0d_rd_cnt got %0d want %0d", t, obs_ra.size(), exp_ra_q.size()); end
      n_vec++; if (word_count !== (CW+1)'(exp_wc)) begin n_err++; $display("FAIL gap%0d_wc got %0d want %0d", t, word_count, exp_wc); end
      n_vec++; if (sum_ok !== exp_sum_ok) begin n_err++; $display("FAIL gap%0d_sum_ok got %0d want %0d", t, sum_ok, exp_sum_ok); end
      n_vec++; if (done_cyc - last_acc_cyc != exp_latency) begin n_err++; $display("FAIL gap%0d_latency got %0d want %0d", t, done_cyc - last_acc_cyc, exp_latency); end
    end
  endtask

  task automatic test_size_cap();
    mon_sel = 1'b1;
    img.delete();
    for (int i = 0; i < 6; i++) img.push_back($urandom());
    model_load(1 << SCW, 1'b0);
    pulse_start(1'b1);
    drive_image(1'b1, 1'b0, -1, 0);
    wait_done();
    n_vec++; if (n_acc != exp_wc) begin n_err++; $display("FAIL cap_accepted got %0d want %0d", n_acc, exp_wc); end
    n_vec++; if (obs_wa.size() != exp_wa_q.size()) begin n_err++; $display("FAIL cap_wr_cnt got %0d want %0d", obs_wa.size(), exp_wa_q.size()); end
    foreach (exp_wa_q[i]) if (i < obs_wa.size()) begin
      n_vec++;
      if (obs_wa[i] !== exp_wa_q[i] || obs_wd[i] !== exp_wd_q[i]) begin n_err++; $display("FAIL cap_wr%0d got %h:%h want %h:%h", i, obs_wa[i], obs_wd[i], exp_wa_q[i], exp_wd_q[i]); end
    end
    n_vec++; if (s_word_count !== (SCW+1)'(exp_wc)) begin n_err++; $display("FAIL cap_wc got %0d want %0d", s_word_count, exp_wc); end
    n_vec++; if (s_sum_ok !== exp_sum_ok || s_done !== 1'b1) begin n_err++; $display("FAIL cap_sum_done got %0d/%0d want %0d/1", s_sum_ok, s_done, exp_sum_ok); end
    n_vec++; if (done_cyc - last_acc_cyc != exp_latency) begin n_err++; $display("FAIL cap_latency got %0d want %0d", done_cyc - last_acc_cyc, exp_latency); end
    mon_sel = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    mon_sel = 1'b0;
    img.delete();
    for (int i = 0; i < 4; i++) img.push_back($urandom());
    pulse_start(1'b0);
    set_src(1'b0, 1'b1, img[0], 1'b0);
    @(posedge clock); #1;
    set_src(1'b0, 1'b1, img[1], 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    set_src(1'b0, 1'b0, '0, 1'b0);
    @(negedge clock);
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rst_mid_state got %0d want %0d", dbg_state, ST_IDLE); end
    n_vec++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL rst_mid_mem_en got %0d want 0", mem_en); end
    n_vec++; if (word_count !== '0) begin n_err++; $display("FAIL rst_mid_wc got %0d want 0", word_count); end
    n_vec++; if (busy !== 1'b0 || done !== 1'b0 || sum_ok !== 1'b0) begin n_err++; $display("FAIL rst_mid_flags got %0d%0d%0d want 000", busy, done, sum_ok); end
    img.delete();
    for (int i = 0; i < 5; i++) img.push_back($urandom());
    model_load(1 << CW, 1'b0);
    pulse_start(1'b0);
    drive_image(1'b0, 1'b1, -1, 0);
    wait_done();
    n_vec++; if (obs_wa.size() != exp_wa_q.size()) begin n_err++; $display("FAIL reload_wr_cnt got %0d want %0d", obs_wa.size(), exp_wa_q.size()); end
    foreach (exp_wa_q[i]) if (i < obs_wa.size()) begin
      n_vec++;
      if (obs_wa[i] !== exp_wa_q[i] || obs_wd[i] !== exp_wd_q[i]) begin n_err++; $display("FAIL reload_wr%0d got %h:%h want %h:%h", i, obs_wa[i], obs_wd[i], exp_wa_q[i], exp_wd_q[i]); end
    end
    n_vec++; if (word_count !== (CW+1)'(exp_wc)) begin n_err++; $display("FAIL reload_wc got %0d want %0d", word_count, exp_wc); end
    n_vec++; if (sum_ok !== exp_sum_ok || done !== 1'b1) begin n_err++; $display("FAIL reload_sum_done got %0d/%0d want %0d/1", sum_ok, done, exp_sum_ok); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fixed_image();
    test_corrupt_readback();
    test_gaps();
    test_size_cap();
    test_reset_mid_load();
    repeat (2) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
